// File: rtl/difftest_snapshot_csr_queue.sv
// Multi-core CSR snapshot capture: per-channel holding registers,
// round-robin arbiter and a shared FIFO drained over valid/ready.
module difftest_snapshot_csr_queue #(
  parameter int NUM_CORES = 2,
  parameter int CNT_W     = 64,
  parameter int DEPTH     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CORES-1:0]       in_valid,
  input  logic [NUM_CORES*CNT_W-1:0] in_minstret,
  input  logic [NUM_CORES*CNT_W-1:0] in_mcycle,
  input  logic [NUM_CORES*8-1:0]     in_coreid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_coreid,
  output logic [CNT_W-1:0]           out_minstret,
  output logic [CNT_W-1:0]           out_mcycle,
  output logic [CNT_W-1:0]           out_delta,
  output logic                       out_lost,
  output logic [31:0]                drop_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef struct packed {
    logic [7:0]       coreid;
    logic [CNT_W-1:0] minstret;
    logic [CNT_W-1:0] mcycle;
    logic [CNT_W-1:0] delta;
    logic             lost;
  } rec_t;

  logic [NUM_CORES-1:0] full_q, full_d;
  logic [NUM_CORES-1:0] lost_q, lost_d;
  logic [NUM_CORES-1:0] gsel, ovr;
  logic [CNT_W-1:0]     hmin_q [NUM_CORES];
  logic [CNT_W-1:0]     hcyc_q [NUM_CORES];
  logic [7:0]           hid_q  [NUM_CORES];
  logic [CNT_W-1:0]     last_q [NUM_CORES];
  logic [PW-1:0]        rr_q, rr_d;
  logic [31:0]          drop_q, drop_d;
  logic [32:0]          drop_sum;
  logic [3:0]           ndrop;

  rec_t                 mem_q [DEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [LW-1:0]        level_q, level_d;
  rec_t                 rec_in, head;

  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic                 push, pop;
  int                   idx;

  // Descending scan so the channel nearest the pointer wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (level_q < LW'(DEPTH)) begin
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_CORES) idx = idx - NUM_CORES;
        if (full_q[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    gsel  = '0;
    ovr   = '0;
    ndrop = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      gsel[i]   = gnt_vld && (gnt_idx == PW'(i));
      ovr[i]    = in_valid[i] && full_q[i] && !gsel[i];
      full_d[i] = in_valid[i] || (full_q[i] && !gsel[i]);
      lost_d[i] = ovr[i] || (lost_q[i] && !gsel[i]);
      ndrop     = ndrop + {3'b0, ovr[i]};
    end
    drop_sum = {1'b0, drop_q} + 33'(ndrop);
    drop_d   = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    rr_d     = rr_q;
    if (gnt_vld)
      rr_d = (int'(gnt_idx) == NUM_CORES - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    rec_in.coreid   = hid_q[gnt_idx];
    rec_in.minstret = hmin_q[gnt_idx];
    rec_in.mcycle   = hcyc_q[gnt_idx];
    rec_in.delta    = hmin_q[gnt_idx] - last_q[gnt_idx];
    rec_in.lost     = lost_q[gnt_idx];
  end

  assign push = gnt_vld;
  assign pop  = (level_q != '0) && out_ready;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      lost_q <= '0;
      rr_q   <= '0;
      drop_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        hmin_q[i] <= '0;
        hcyc_q[i] <= '0;
        hid_q[i]  <= '0;
        last_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      lost_q <= lost_d;
      rr_q   <= rr_d;
      drop_q <= drop_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (in_valid[i]) begin
          hmin_q[i] <= in_minstret[i*CNT_W +: CNT_W];
          hcyc_q[i] <= in_mcycle[i*CNT_W +: CNT_W];
          hid_q[i]  <= in_coreid[i*8 +: 8];
        end
        if (gsel[i]) last_q[i] <= hmin_q[i];
      end
    end
  end

  // Storage is cleared so the drain outputs read zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= rec_in;
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      level_q <= level_d;
    end
  end

  assign head         = mem_q[rp_q];
  assign out_valid    = (level_q != '0);
  assign out_coreid   = head.coreid;
  assign out_minstret = head.minstret;
  assign out_mcycle   = head.mcycle;
  assign out_delta    = head.delta;
  assign out_lost     = head.lost;
  assign drop_count   = drop_q;
  assign level        = level_q;

`ifdef DIFFTEST
  always @(posedge clock) begin
    if (!reset) begin
      assert (level_q <= LW'(DEPTH));
      assert (!(push && level_q == LW'(DEPTH)));
    end
  end
`endif

endmodule

// File: tb/tb_difftest_snapshot_csr_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_difftest_snapshot_csr_queue;
  localparam int N  = 2;
  localparam int W  = 64;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     in_valid = '0;
  logic [N*W-1:0]   in_minstret = '0;
  logic [N*W-1:0]   in_mcycle = '0;
  logic [N*8-1:0]   in_coreid = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_coreid;
  logic [W-1:0]     out_minstret, out_mcycle, out_delta;
  logic             out_lost;
  logic [31:0]      drop_count;
  logic [LW-1:0]    level;

  difftest_snapshot_csr_queue #(.NUM_CORES(N), .CNT_W(W), .DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_minstret(in_minstret),
    .in_mcycle(in_mcycle), .in_coreid(in_coreid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_coreid(out_coreid), .out_minstret(out_minstret),
    .out_mcycle(out_mcycle), .out_delta(out_delta),
    .out_lost(out_lost), .drop_count(drop_count), .level(level)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]   id;
    logic [W-1:0] mi, mc, dl;
    logic         lost;
  } rec_t;

  rec_t         mq[$];
  bit           m_full[N];
  bit           m_lost[N];
  logic [W-1:0] m_hmi[N], m_hmc[N], m_last[N];
  logic [7:0]   m_hid[N];
  int           m_rr;
  logic [31:0]  m_drops;

  rec_t got[$];

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_lost[i] = 0;
      m_hmi[i] = '0; m_hmc[i] = '0; m_last[i] = '0; m_hid[i] = '0;
    end
    m_rr = 0;
    m_drops = '0;
  endtask

  task automatic model_step();
    int g, j;
    rec_t r;
    g = -1;
    if (mq.size() < D)
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (g < 0 && m_full[j]) g = j;
      end
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (g >= 0) begin
      r.id = m_hid[g]; r.mi = m_hmi[g]; r.mc = m_hmc[g];
      r.dl = m_hmi[g] - m_last[g]; r.lost = m_lost[g];
      mq.push_back(r);
      m_last[g] = m_hmi[g]; m_lost[g] = 0; m_full[g] = 0;
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++)
      if (in_valid[i]) begin
        if (m_full[i]) begin
          m_lost[i] = 1;
          if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
        end
        m_full[i] = 1;
        m_hmi[i] = in_minstret[i*W +: W];
        m_hmc[i] = in_mcycle[i*W +: W];
        m_hid[i] = in_coreid[i*8 +: 8];
      end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic set_in(int ch, logic [W-1:0] mi, logic [W-1:0] mc,
                        logic [7:0] id);
    in_valid[ch] = 1'b1;
    in_minstret[ch*W +: W] = mi;
    in_mcycle[ch*W +: W] = mc;
    in_coreid[ch*8 +: 8] = id;
  endtask

  task automatic grab();
    rec_t r;
    if (out_valid && out_ready) begin
      r.id = out_coreid; r.mi = out_minstret; r.mc = out_mcycle;
      r.dl = out_delta; r.lost = out_lost;
      got.push_back(r);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++;
    if (level !== '0) begin failures++;
      $display("FAIL reset_level got=%0d exp=0", level); end
    checks++;
    if (drop_count !== 32'd0) begin failures++;
      $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    checks++;
    if ({out_coreid, out_minstret, out_mcycle, out_delta, out_lost} !== '0)
    begin failures++;
      $display("FAIL reset_data got=%0h/%0h/%0h/%0h/%0b exp=0",
               out_coreid, out_minstret, out_mcycle, out_delta, out_lost);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    set_in(0, 64'd100, 64'd250, 8'd0);
    tick();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b0) begin failures++;
      $display("FAIL single_early got=%0b exp=0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin failures++;
      $display("FAIL single_valid got=%0b exp=1", out_valid); end
    checks++;
    if (out_minstret !== 64'd100 || out_mcycle !== 64'd250 ||
        out_coreid !== 8'd0) begin failures++;
      $display("FAIL single_data got=%0d/%0d/%0d exp=100/250/0",
               out_minstret, out_mcycle, out_coreid); end
    checks++;
    if (out_delta !== 64'd100 || out_lost !== 1'b0) begin failures++;
      $display("FAIL single_delta got=%0d/%0b exp=100/0",
               out_delta, out_lost); end
    tick();
    checks++;
    if (level !== '0 || out_valid !== 1'b0) begin failures++;
      $display("FAIL single_drain got=%0d/%0b exp=0/0", level, out_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = '0;
      if (c == 0) begin
        set_in(0, 64'd10, 64'd1010, 8'd0);
        set_in(1, 64'd20, 64'd1020, 8'd1);
      end
      if (c == 1) begin
        set_in(0, 64'd11, 64'd1011, 8'd0);
        set_in(1, 64'd21, 64'd1021, 8'd1);
      end
      grab();
      tick();
    end
    in_valid = '0;
    checks++;
    if (got.size() != 3) begin failures++;
      $display("FAIL rr_count got=%0d exp=3", got.size()); end
    else begin
      checks++;
      if (got[0].id !== 8'd0 || got[0].mi !== 64'd10) begin failures++;
        $display("FAIL rr_first got=%0d/%0d exp=0/10", got[0].id, got[0].mi);
      end
      checks++;
      if (got[1].id !== 8'd1 || got[1].mi !== 64'd21 ||
          got[1].lost !== 1'b1 || got[1].dl !== 64'd21) begin failures++;
        $display("FAIL rr_second got=%0d/%0d/%0b/%0d exp=1/21/1/21",
                 got[1].id, got[1].mi, got[1].lost, got[1].dl); end
      checks++;
      if (got[2].id !== 8'd0 || got[2].mi !== 64'd11 ||
          got[2].dl !== 64'd1) begin failures++;
        $display("FAIL rr_third got=%0d/%0d/%0d exp=0/11/1",
                 got[2].id, got[2].mi, got[2].dl); end
    end
    checks++;
    if (drop_count !== 32'd1) begin failures++;
      $display("FAIL rr_drop got=%0d exp=1", drop_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_in(0, 64'(1000 + k), 64'(2000 + k), 8'd0);
      tick();
    end
    in_valid = '0;
    checks++;
    if (level !== LW'(4)) begin failures++;
      $display("FAIL ovf_level got=%0d exp=4", level); end
    checks++;
    if (drop_count !== 32'd1) begin failures++;
      $display("FAIL ovf_drop got=%0d exp=1", drop_count); end
    out_ready = 1'b1;
    grab();
    tick();
    checks++;
    if (level !== LW'(3)) begin failures++;
      $display("FAIL full_pop_no_push got=%0d exp=3", level); end
    out_ready = 1'b0;
    tick();
    checks++;
    if (level !== LW'(4)) begin failures++;
      $display("FAIL late_push got=%0d exp=4", level); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin grab(); tick(); end
    checks++;
    if (got.size() != 5) begin failures++;
      $display("FAIL ovf_count got=%0d exp=5", got.size()); end
    else begin
      checks++;
      if (got[3].mi !== 64'd1003 || got[3].lost !== 1'b0) begin failures++;
        $display("FAIL ovf_fourth got=%0d/%0b exp=1003/0",
                 got[3].mi, got[3].lost); end
      checks++;
      if (got[4].mi !== 64'd1005 || got[4].lost !== 1'b1 ||
          got[4].dl !== 64'd2) begin failures++;
        $display("FAIL ovf_fifth got=%0d/%0b/%0d exp=1005/1/2",
                 got[4].mi, got[4].lost, got[4].dl); end
    end
  endtask

  task automatic test_delta_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = '0;
      if (c == 0) set_in(1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd1, 8'd1);
      if (c == 3) set_in(1, 64'h5, 64'd2, 8'd1);
      grab();
      tick();
    end
    in_valid = '0;
    checks++;
    if (got.size() != 2) begin failures++;
      $display("FAIL wrap_count got=%0d exp=2", got.size()); end
    else begin
      checks++;
      if (got[0].dl !== 64'hFFFF_FFFF_FFFF_FFF0) begin failures++;
        $display("FAIL wrap_first got=%0h exp=fffffffffffffff0", got[0].dl);
      end
      checks++;
      if (got[1].dl !== 64'h15) begin failures++;
        $display("FAIL wrap_delta got=%0h exp=15", got[1].dl); end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset();
    c = 0;
    while (!(mq.size() == 3 && m_full[0] && m_full[1]) && c < 20) begin
      set_in(0, {$urandom, $urandom}, 64'(c), 8'd0);
      set_in(1, {$urandom, $urandom}, 64'(c), 8'd1);
      tick();
      c++;
    end
    in_valid = '0;
    checks++;
    if (c >= 20 || level !== LW'(3)) begin failures++;
      $display("FAIL mid_setup got=%0d exp=3", level); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== '0 || drop_count !== 32'd0)
    begin failures++;
      $display("FAIL mid_async got=%0b/%0d/%0d exp=0/0/0",
               out_valid, level, drop_count); end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    got.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = '0;
      if (k == 0) set_in(0, 64'd777, 64'd9, 8'd0);
      grab();
      tick();
    end
    in_valid = '0;
    checks++;
    if (got.size() != 1 || got[0].dl !== 64'd777) begin failures++;
      $display("FAIL mid_after got=%0d recs exp=1 rec delta 777",
               got.size()); end
  endtask

  task automatic test_random();
    int dens;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (out_valid !== (mq.size() != 0)) begin failures++;
        $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b",
                 c, out_valid, mq.size() != 0); end
      checks++;
      if (level !== LW'(mq.size())) begin failures++;
        $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d",
                 c, level, mq.size()); end
      checks++;
      if (drop_count !== m_drops) begin failures++;
        $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d",
                 c, drop_count, m_drops); end
      if (mq.size() != 0) begin
        checks++;
        if (out_coreid !== mq[0].id || out_minstret !== mq[0].mi ||
            out_mcycle !== mq[0].mc) begin failures++;
          $display("FAIL rnd_head cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h",
                   c, out_coreid, out_minstret, out_mcycle,
                   mq[0].id, mq[0].mi, mq[0].mc); end
        checks++;
        if (out_delta !== mq[0].dl || out_lost !== mq[0].lost) begin
          failures++;
          $display("FAIL rnd_delta cyc=%0d got=%0h/%0b exp=%0h/%0b",
                   c, out_delta, out_lost, mq[0].dl, mq[0].lost); end
      end
      dens = 1 + (c / 250) % 4;
      in_valid = '0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 4) < dens)
          set_in(i, ($urandom_range(0, 1) != 0) ? {$urandom, $urandom}
                                                : 64'($urandom_range(0, 99)),
                 {$urandom, $urandom}, 8'($urandom));
      out_ready = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                       : ($urandom_range(0, 3) == 0);
      tick();
    end
    in_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_delta_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
